fetch_stage: RTL and testbench

- IF stage of the five-stage MIPS pipeline. Owns the PC register and the IF/ID pipeline register.
- Fetches each instruction from the instruction memory over a req/ack handshake that may insert wait states.
- Every cycle it accepts the next PC computed by the decode stage (d_NPC). It drives f_PC, IFID_PC and IFID_Instr into decode, and raises fetch_busy to the hazard unit while a fetch is outstanding.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the IF stage and the instruction memory.
// The master drives the request and address; the memory answers with ack and the instruction word.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the five-stage MIPS pipeline: owns the PC and the IF/ID register.
// Fetches over a req/ack bus with wait states and parks a stalled word in a one-entry buffer.
module fetch_stage #(
   parameter logic [31:0] PC_RESET  = 32'h00003000,
   parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic [31:0]         d_NPC,
   fetch_stage_if.master       imem,
   output logic [31:0]         f_PC,
   output logic [31:0]         IFID_PC,
   output logic [31:0]         IFID_Instr,
   output logic                fetch_busy
);

   typedef enum logic {
      FETCH = 1'b0,
      READY = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifidPc_q, ifidPc_d;
   logic [31:0] ifidInstr_q, ifidInstr_d;
   logic [31:0] buf_q, buf_d;
   logic        bufValid_q, bufValid_d;
   logic        adv;
   logic        capture;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH: begin
            if (imem.imem_ack && stall) begin
               state_d = READY;
            end
         end
         READY: begin
            if (!stall && bufValid_q) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   // adv moves the fetched word into IF/ID; capture parks it while decode is stalled.
   always_comb begin
      imem.imem_req  = 1'b0;
      imem.imem_addr = pc_q;
      fetch_busy     = 1'b0;
      adv            = 1'b0;
      capture        = 1'b0;
      case (state_q)
         FETCH: begin
            imem.imem_req = 1'b1;
            fetch_busy    = !imem.imem_ack;
            adv           = imem.imem_ack && !stall;
            capture       = imem.imem_ack && stall;
         end
         READY: begin
            adv = !stall && bufValid_q;
         end
         default: begin
            imem.imem_req = 1'b0;
         end
      endcase
   end

   always_comb begin
      pc_d        = pc_q;
      ifidPc_d    = ifidPc_q;
      ifidInstr_d = ifidInstr_q;
      buf_d       = buf_q;
      bufValid_d  = bufValid_q;
      if (adv) begin
         pc_d        = d_NPC;
         ifidPc_d    = pc_q;
         ifidInstr_d = (state_q == READY) ? buf_q : imem.imem_rdata;
         bufValid_d  = 1'b0;
      end else if (capture) begin
         buf_d      = imem.imem_rdata;
         bufValid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q        <= PC_RESET;
         ifidPc_q    <= PC_RESET;
         ifidInstr_q <= NOP_INSTR;
         buf_q       <= 32'h0;
         bufValid_q  <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         ifidPc_q    <= ifidPc_d;
         ifidInstr_q <= ifidInstr_d;
         buf_q       <= buf_d;
         bufValid_q  <= bufValid_d;
      end
   end

   assign f_PC       = pc_q;
   assign IFID_PC    = ifidPc_q;
   assign IFID_Instr = ifidInstr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a "who holds the fetched word" reference model.
// Directed sequences cover zero-wait fetch, wait states, stall-on-ack, branch delay slot and async reset.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [31:0] dNpc;
   logic [31:0] fPc;
   logic [31:0] ifidPc;
   logic [31:0] ifidInstr;
   logic        fetchBusy;

   int vectors;
   int miscompares;

   // Reference model: the PC, the IF/ID contents, and whether the word for the
   // current PC has already been received but not yet handed to decode.
   logic [31:0] mPc;
   logic [31:0] mIfidPc;
   logic [31:0] mIfidInstr;
   logic        mHaveWord;
   logic [31:0] mWord;

   fetch_stage_if imem ();

   fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .d_NPC      (dNpc),
      .imem       (imem),
      .f_PC       (fPc),
      .IFID_PC    (ifidPc),
      .IFID_Instr (ifidInstr),
      .fetch_busy (fetchBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %08h expected %08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mPc        = 32'h00003000;
      mIfidPc    = 32'h00003000;
      mIfidInstr = 32'h00000000;
      mHaveWord  = 1'b0;
      mWord      = 32'h0;
   endtask

   // One pipeline cycle: drive inputs after the falling edge, check the
   // combinational bus outputs, step the model at the rising edge, then check
   // the registered outputs at the following falling edge.
   task automatic applyStimulus(input logic s, input logic a, input logic [31:0] rd, input logic [31:0] npc);
      logic        avail;
      logic [31:0] w;
      stall           = s;
      imem.imem_ack   = a;
      imem.imem_rdata = rd;
      dNpc            = npc;
      #1;
      checkOutput("imem_req", 32'(imem.imem_req), 32'(!mHaveWord));
      if (!mHaveWord) checkOutput("imem_addr", imem.imem_addr, mPc);
      checkOutput("fetch_busy", 32'(fetchBusy), 32'(!mHaveWord && !a));
      @(posedge clk);
      avail = 1'b0;
      w     = 32'h0;
      if (mHaveWord) begin
         avail = 1'b1;
         w     = mWord;
      end else if (a) begin
         avail = 1'b1;
         w     = rd;
      end
      if (avail && !s) begin
         mIfidPc    = mPc;
         mIfidInstr = w;
         mPc        = npc;
         mHaveWord  = 1'b0;
      end else if (avail) begin
         mHaveWord = 1'b1;
         mWord     = w;
      end
      @(negedge clk);
      checkOutput("f_PC", fPc, mPc);
      checkOutput("IFID_PC", ifidPc, mIfidPc);
      checkOutput("IFID_Instr", ifidInstr, mIfidInstr);
   endtask

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return (addr * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset           = 1'b0;
      stall           = 1'b0;
      dNpc            = 32'h0;
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = 32'h0;
      modelReset();

      @(negedge clk);
      checkOutput("reset f_PC", fPc, 32'h00003000);
      checkOutput("reset IFID_PC", ifidPc, 32'h00003000);
      checkOutput("reset IFID_Instr", ifidInstr, 32'h00000000);
      checkOutput("reset req", 32'(imem.imem_req), 32'h1);
      @(negedge clk);
      reset = 1'b1;

      // Zero-wait memory, sequential PCs.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, memWord(mPc), mPc + 32'd4);

      // Two wait cycles at 0x300C, then the ack cycle advances.
      applyStimulus(1'b0, 1'b0, 32'hDEADBEEF, mPc + 32'd4);
      applyStimulus(1'b0, 1'b0, 32'hDEADBEEF, mPc + 32'd4);
      applyStimulus(1'b0, 1'b1, memWord(mPc), mPc + 32'd4);

      // Reset dropped asynchronously while the fetch at 0x3010 waits.
      checkOutput("pre-reset f_PC", fPc, 32'h00003010);
      applyStimulus(1'b0, 1'b0, 32'h0, mPc + 32'd4);
      #2 reset = 1'b0;
      #1;
      checkOutput("async f_PC", fPc, 32'h00003000);
      checkOutput("async IFID_PC", ifidPc, 32'h00003000);
      checkOutput("async IFID_Instr", ifidInstr, 32'h00000000);
      modelReset();
      @(negedge clk);
      #2 reset = 1'b1;

      // Stall in the ack cycle, then stay parked in READY with ack held high.
      applyStimulus(1'b0, 1'b1, memWord(mPc), mPc + 32'd4);
      applyStimulus(1'b1, 1'b1, 32'h8C010000, mPc + 32'd4);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, $urandom, 32'h0000BAD0);
      applyStimulus(1'b0, 1'b0, 32'h0, mPc + 32'd4);
      checkOutput("parked word", ifidInstr, 32'h8C010000);
      checkOutput("parked PC", ifidPc, 32'h00003004);

      // Branch in D targeting 0x3040 while the delay slot at 0x3008 waits one cycle.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h00003040);
      applyStimulus(1'b0, 1'b1, memWord(mPc), 32'h00003040);
      checkOutput("delay slot PC", ifidPc, 32'h00003008);
      checkOutput("branch target", fPc, 32'h00003040);

      // Random traffic: random stalls, acks, garbage data while not acked, random targets.
      for (int i = 0; i < 400; i++) begin
         logic        s;
         logic        a;
         logic [31:0] npc;
         s   = ($urandom_range(0, 3) == 0);
         a   = ($urandom_range(0, 2) != 0);
         npc = ($urandom_range(0, 4) == 0) ? (32'h00003000 + (32'($urandom_range(0, 255)) << 2))
                                           : (mPc + 32'd4);
         applyStimulus(s, a, a ? memWord(mPc) : $urandom, npc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
